// File: rtl/perf_counter_bank.sv
// Bank of event counters with wrap/saturate overflow, sticky overflow flags,
// atomic snapshot into shadow registers, registered readout and software preload.
module perf_counter_bank #(
  parameter int NUM_CNT  = 7,
  parameter int WIDTH    = 16,
  parameter int INC_W    = 2,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CNT*INC_W-1:0]   inc,
  input  logic                       clear,
  input  logic                       snapshot,
  input  logic                       wr_en,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic [SEL_W-1:0]           rd_sel,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [NUM_CNT-1:0]         ovf,
  output logic                       irq_ovf
);

  logic [WIDTH-1:0] cnt_q    [NUM_CNT];
  logic [WIDTH-1:0] cnt_d    [NUM_CNT];
  logic [WIDTH-1:0] shadow_q [NUM_CNT];
  logic [WIDTH-1:0] shadow_d [NUM_CNT];
  logic [WIDTH:0]   sum_ch   [NUM_CNT];
  logic [INC_W-1:0] inc_ch   [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Carry out of the extended sum selects between wrap and clamp-to-all-ones.
  function automatic logic [WIDTH-1:0] sat_wrap(input logic [WIDTH:0] sum);
    if (sum[WIDTH] && (SAT_MODE != 0)) return '1;
    return sum[WIDTH-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      inc_ch[i] = inc[i*INC_W +: INC_W];
      sum_ch[i] = {1'b0, cnt_q[i]} + {{(WIDTH+1-INC_W){1'b0}}, inc_ch[i]};
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i]    = cnt_q[i];
      // Shadows always take the pre-update count, so snapshot+clear loses nothing.
      shadow_d[i] = snapshot ? cnt_q[i] : shadow_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (wr_en && (wr_sel == SEL_W'(i))) begin
        cnt_d[i] = wr_data;
        ovf_d[i] = 1'b0;
      end else if (enable && (inc_ch[i] != '0)) begin
        cnt_d[i] = sat_wrap(sum_ch[i]);
        if (sum_ch[i][WIDTH]) ovf_d[i] = 1'b1;
      end
    end
  end

  // Reads see the shadow as it stood before this edge's snapshot.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (rd_sel == SEL_W'(i)) rd_data_d = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ovf      = ovf_q;
  assign irq_ovf  = |ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: one wrapping and one saturating instance driven in
// parallel, checked every cycle against an arithmetic reference model.
module tb_perf_counter_bank;

  localparam int N = 7;

  logic        clk, reset, enable, clear, snapshot, wr_en, rd_en;
  logic [13:0] inc;
  logic [2:0]  wr_sel, rd_sel;
  logic [15:0] wr_data;
  logic [15:0] rd_data_w, rd_data_s;
  logic        rd_valid_w, rd_valid_s, irq_w, irq_s;
  logic [6:0]  ovf_w, ovf_s;

  perf_counter_bank #(.NUM_CNT(7), .WIDTH(16), .INC_W(2), .SAT_MODE(0), .SEL_W(3)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .inc(inc), .clear(clear),
    .snapshot(snapshot), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
    .ovf(ovf_w), .irq_ovf(irq_w));

  perf_counter_bank #(.NUM_CNT(7), .WIDTH(16), .INC_W(2), .SAT_MODE(1), .SEL_W(3)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .inc(inc), .clear(clear),
    .snapshot(snapshot), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .ovf(ovf_s), .irq_ovf(irq_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: index 0 = wrap instance, 1 = saturate instance.
  int mc [2][N];
  int ms [2][N];
  bit mo [2][N];
  int mrd [2];
  bit mrv [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin mc[m][i] = 0; ms[m][i] = 0; mo[m][i] = 0; end
      mrd[m] = 0; mrv[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rd_en) begin
        mrv[m] = 1;
        mrd[m] = (int'(rd_sel) < N) ? ms[m][rd_sel] : 0;
      end else mrv[m] = 0;
      for (int i = 0; i < N; i++) begin
        int pre, step, s;
        pre  = mc[m][i];
        step = (int'(inc) >> (2*i)) & 3;
        if (snapshot) ms[m][i] = pre;
        if (clear) begin mc[m][i] = 0; mo[m][i] = 0; end
        else if (wr_en && int'(wr_sel) == i) begin mc[m][i] = int'(wr_data); mo[m][i] = 0; end
        else if (enable && step != 0) begin
          s = pre + step;
          if (s > 65535) begin
            mo[m][i] = 1;
            mc[m][i] = (m == 1) ? 65535 : s - 65536;
          end else mc[m][i] = s;
        end
      end
    end
  endtask

  function automatic logic [6:0] ovf_vec(input int m);
    logic [6:0] v;
    for (int i = 0; i < N; i++) v[i] = mo[m][i];
    return v;
  endfunction

  task automatic compare_all();
    check("rd_valid_wrap", 32'(rd_valid_w), 32'(mrv[0]));
    check("rd_data_wrap",  32'(rd_data_w),  32'(mrd[0]));
    check("ovf_wrap",      32'(ovf_w),      32'(ovf_vec(0)));
    check("irq_wrap",      32'(irq_w),      32'(ovf_vec(0) != 0));
    check("rd_valid_sat",  32'(rd_valid_s), 32'(mrv[1]));
    check("rd_data_sat",   32'(rd_data_s),  32'(mrd[1]));
    check("ovf_sat",       32'(ovf_s),      32'(ovf_vec(1)));
    check("irq_sat",       32'(irq_s),      32'(ovf_vec(1) != 0));
  endtask

  task automatic idle();
    enable = 0; inc = '0; clear = 0; snapshot = 0; wr_en = 0; wr_sel = '0;
    wr_data = '0; rd_en = 0; rd_sel = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Snapshot live counters, then read one channel back and check fixed expectations.
  task automatic peek(input string tag, input int ch, input logic [15:0] exp_w, input logic [15:0] exp_s);
    idle(); snapshot = 1; tick();
    idle(); rd_en = 1; rd_sel = 3'(ch); tick();
    check({tag, "_wrap"}, 32'(rd_data_w), 32'(exp_w));
    check({tag, "_sat"},  32'(rd_data_s), 32'(exp_s));
    check({tag, "_vld"},  32'(rd_valid_w & rd_valid_s), 32'd1);
    idle();
  endtask

  task automatic write_ch(input int ch, input logic [15:0] d);
    idle(); wr_en = 1; wr_sel = 3'(ch); wr_data = d; tick(); idle();
  endtask

  initial begin
    idle();
    reset = 0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;

    // Wrap / overflow then clear
    write_ch(0, 16'hFFFE);
    enable = 1; inc = 14'd3; tick(); idle();
    check("t1_ovf0_w", 32'(ovf_w[0]), 32'd1);
    check("t1_irq_w",  32'(irq_w), 32'd1);
    peek("t1_cnt0", 0, 16'h0001, 16'hFFFF);
    clear = 1; tick(); idle();
    check("t1_clr_ovf", 32'(ovf_w), 32'd0);
    check("t1_clr_irq", 32'(irq_w), 32'd0);
    peek("t1_cnt0_clr", 0, 16'h0000, 16'h0000);

    // Saturation on channel 2
    write_ch(2, 16'hFFFD);
    repeat (2) begin enable = 1; inc = 14'd3 << 4; tick(); end
    idle();
    check("t2_ovf2_s", 32'(ovf_s[2]), 32'd1);
    peek("t2_cnt2", 2, 16'h0003, 16'hFFFF);
    enable = 1; inc = 14'd3 << 4; tick(); idle();
    peek("t2_hold", 2, 16'h0006, 16'hFFFF);

    // Freeze-and-clear, then read racing a snapshot
    clear = 1; tick(); idle();
    repeat (5) begin enable = 1; inc = 14'd1 << 2; tick(); end
    enable = 1; inc = 14'd1 << 2; snapshot = 1; clear = 1; tick(); idle();
    enable = 1; inc = 14'd1 << 2; snapshot = 1; rd_en = 1; rd_sel = 3'd1; tick(); idle();
    check("t3_pre_clr", 32'(rd_data_w), 32'd5);
    rd_en = 1; rd_sel = 3'd1; tick(); idle();
    check("t3_live0", 32'(rd_data_w), 32'd0);
    peek("t3_live1", 1, 16'h0001, 16'h0001);

    // Priority clear > write > count; out-of-range write ignored
    clear = 1; wr_en = 1; wr_sel = 3'd3; wr_data = 16'h00AA; enable = 1; inc = 14'd1 << 6; tick(); idle();
    peek("t4_clr_wins", 3, 16'h0000, 16'h0000);
    wr_en = 1; wr_sel = 3'd3; wr_data = 16'h00AA; enable = 1; inc = 14'd1 << 6; tick(); idle();
    peek("t4_wr_wins", 3, 16'h00AA, 16'h00AA);
    write_ch(7, 16'hBEEF);
    peek("t4_sel7", 3, 16'h00AA, 16'h00AA);

    // Read latency, one-cycle valid, hold, out-of-range select
    write_ch(4, 16'h1234);
    peek("t5_rd4", 4, 16'h1234, 16'h1234);
    tick();
    check("t5_vld_drop", 32'(rd_valid_w), 32'd0);
    check("t5_hold", 32'(rd_data_w), 32'h1234);
    rd_en = 1; rd_sel = 3'd7; tick(); idle();
    check("t5_sel7", 32'(rd_data_w), 32'd0);
    check("t5_sel7_vld", 32'(rd_valid_w), 32'd1);

    // enable=0 freezes counting
    enable = 0; inc = '1; repeat (3) tick(); idle();
    peek("t6_frozen", 4, 16'h1234, 16'h1234);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      inc      = 14'($urandom);
      clear    = ($urandom_range(0, 39) == 0);
      snapshot = ($urandom_range(0, 3) == 0);
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_sel   = 3'($urandom);
      wr_data  = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom);
      rd_en    = ($urandom_range(0, 1) != 0);
      rd_sel   = 3'($urandom);
      tick();
    end
    idle();

    // Async reset between edges
    enable = 1; inc = '1; rd_en = 1; rd_sel = 3'd4; tick();
    #3;
    reset = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1;
    idle();
    peek("t6_after_rst", 4, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
